// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux_if
// Purpose  : Bundles the N input valid/ready channels and the single merged
//            output channel of rr_arb_mux.
//            N = 2**SEL_BITS input channels.
// Signals  : in_data   [N-1:0][DATA_BITS-1:0]  per-channel data
//            in_valid  [N-1:0]                 per-channel valid
//            in_ready  [N-1:0]                 per-channel ready (one-hot or 0)
//            out_data  [DATA_BITS-1:0]         merged data
//            out_sel   [SEL_BITS-1:0]          source channel of out_data
//            out_valid                         merged valid
//            out_ready                         downstream ready
// Modports : master - drives inputs and consumes the output (producer/sink side)
//            slave  - the arbitrating multiplexer itself
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arb_mux_if #(
    parameter int DATA_BITS = 8,
    parameter int SEL_BITS  = 2
);
    localparam int N = 2 ** SEL_BITS;

    logic [N-1:0][DATA_BITS-1:0] in_data;
    logic [N-1:0]                in_valid;
    logic [N-1:0]                in_ready;
    logic [DATA_BITS-1:0]        out_data;
    logic [SEL_BITS-1:0]         out_sel;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : Registered round-robin arbitrating multiplexer. Merges
//            N = 2**SEL_BITS valid/ready input channels onto one registered
//            output slot and tags every word with its source index so a
//            downstream demultiplexer can route responses back.
// Ports    : clk    - single clock, rising edge
//            rst_n  - asynchronous assert, active-low reset
//            bus    - rr_arb_mux_if.slave (in_data/in_valid/in_ready,
//                     out_data/out_sel/out_valid/out_ready)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
    parameter int DATA_BITS = 8,
    parameter int SEL_BITS  = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rr_arb_mux_if.slave      bus
);
    localparam int N = 2 ** SEL_BITS;

    // Output slot and arbitration pointer.
    logic [DATA_BITS-1:0] r_out_data;
    logic [SEL_BITS-1:0]  r_out_sel;
    logic                 r_out_valid;
    logic [SEL_BITS-1:0]  r_ptr;

    logic                 w_load;
    logic                 w_any;
    logic [SEL_BITS-1:0]  w_grant;
    logic [N-1:0]         w_ready;

    // The slot can take a word when it is empty or being drained this cycle,
    // which gives full throughput with a single register stage.
    assign w_load = ~r_out_valid | bus.out_ready;
    assign w_any  = |bus.in_valid;

    // Rotating priority search: start at r_ptr and walk upward modulo N.
    // The index arithmetic is SEL_BITS wide, so the wrap is free.
    always_comb begin : p_arb
        logic                found;
        logic [SEL_BITS-1:0] idx;
        w_grant = r_ptr;
        found   = 1'b0;
        idx     = r_ptr;
        for (int i = 0; i < N; i++) begin
            idx = r_ptr + SEL_BITS'(i);
            if (!found && bus.in_valid[idx]) begin
                w_grant = idx;
                found   = 1'b1;
            end
        end
    end

    // Only the granted channel sees ready, and only if it is actually valid
    // (w_any guarantees the search found a valid index).
    always_comb begin : p_ready
        w_ready = '0;
        if (w_load && w_any) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_slot
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_data  <= bus.in_data[w_grant];
                r_out_sel   <= w_grant;
                r_out_valid <= 1'b1;
                r_ptr       <= w_grant + SEL_BITS'(1);
            end else begin
                // Slot drained with nothing to refill: data/sel keep their
                // last values, the pointer stays where it was.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
